spi_req_arbiter: RTL and testbench

Round-robin arbiter/sequencer that shares one byte-wide SPI master engine between N_REQ on-chip requesters. Each granted requester gets one byte transaction. The block issues the start pulse, tracks completion, and routes the received byte back to the owning requester. A lock input allows back-to-back bursts, and a watchdog recovers from a missing done pulse. It sits between the requester logic and the SPI master. Its m_sel output drives the external chip-select demux.

---
 rtl/spi_pkg.sv | 18 +
 rtl/spi_rr_pick.sv | 38 +++
 rtl/spi_req_arbiter.sv | 104 ++++++++++
 tb/tb_spi_req_arbiter.sv | 341 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/spi_pkg.sv
// Shared types and constants for the SPI requester arbiter and its
// helper logic.
package spi_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } arb_state_t;

  localparam int SPI_BYTE_W      = 8;
  localparam int DEFAULT_TIMEOUT = 1024;

  // An index into a set of n items, but never narrower than one bit.
  function automatic int clog2_min1(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/spi_rr_pick.sv
// Combinational round-robin winner select with a sticky-owner option.
// It can be reused by any arbiter that shares a peripheral between requesters.
module spi_rr_pick
  import spi_pkg::*;
#(
  parameter  int N_REQ = 4,
  localparam int SEL_W = clog2_min1(N_REQ)
) (
  input  logic [N_REQ-1:0] req,
  input  logic [SEL_W-1:0] last,
  input  logic             lock_hold,
  output logic [SEL_W-1:0] win,
  output logic             win_valid
);

  logic [SEL_W-1:0] idx;

  always_comb begin
    // NOTE: every output gets a default first so no path leaves it unassigned (no latch).
    win       = last;
    win_valid = 1'b0;
    idx       = last;
    if (lock_hold && req[last]) begin
      win_valid = 1'b1;
    end else begin
      // Scan from the farthest offset down, so the nearest requester after
      // 'last' is the final assignment and therefore the winner.
      for (int off = N_REQ; off >= 1; off--) begin
        idx = SEL_W'((int'(last) + off) % N_REQ);
        if (req[idx]) begin
          win       = idx;
          win_valid = 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/spi_req_arbiter.sv
// Round-robin sequencer sharing one byte-wide SPI master between N_REQ
// requesters, with burst lock and a watchdog for a missing m_done.
module spi_req_arbiter
  import spi_pkg::*;
#(
  parameter  int N_REQ   = 4,
  parameter  int TIMEOUT = DEFAULT_TIMEOUT,
  localparam int SEL_W   = clog2_min1(N_REQ)
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic [N_REQ-1:0]            req,
  input  logic [N_REQ-1:0]            req_lock,
  input  logic [SPI_BYTE_W*N_REQ-1:0] req_data,
  output logic [N_REQ-1:0]            gnt,
  output logic [N_REQ-1:0]            rsp_valid,
  output logic [SPI_BYTE_W-1:0]       rsp_data,
  output logic                        rsp_err,
  output logic                        busy,
  output logic                        m_start,
  output logic [SPI_BYTE_W-1:0]       m_tx_data,
  output logic [SEL_W-1:0]            m_sel,
  input  logic                        m_done,
  input  logic [SPI_BYTE_W-1:0]       m_rx_data
);

  localparam int               WD_W    = $clog2(TIMEOUT) + 1;
  localparam logic [WD_W-1:0]  WD_LAST = WD_W'(TIMEOUT - 1);
  localparam logic [N_REQ-1:0] ONE_HOT = N_REQ'(1);

  arb_state_t       state;
  logic [SEL_W-1:0] last;
  logic             lock_hold;
  logic [WD_W-1:0]  wdog;
  logic [SEL_W-1:0] win;
  logic             win_valid;

  spi_rr_pick #(.N_REQ(N_REQ)) u_pick (
    .req       (req),
    .last      (last),
    .lock_hold (lock_hold),
    .win       (win),
    .win_valid (win_valid)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      // NOTE: sequential state uses non-blocking assignments so every register
      // samples the pre-edge values regardless of statement order.
      state     <= IDLE;
      last      <= SEL_W'(N_REQ - 1);
      lock_hold <= 1'b0;
      wdog      <= '0;
      gnt       <= '0;
      rsp_valid <= '0;
      rsp_data  <= '0;
      rsp_err   <= 1'b0;
      busy      <= 1'b0;
      m_start   <= 1'b0;
      m_tx_data <= '0;
      m_sel     <= '0;
    end else begin
      gnt       <= '0;
      m_start   <= 1'b0;
      rsp_valid <= '0;
      rsp_err   <= 1'b0;
      case (state)
        IDLE: begin
          if (win_valid) begin
            gnt       <= ONE_HOT << win;
            m_start   <= 1'b1;
            m_tx_data <= req_data[win*SPI_BYTE_W +: SPI_BYTE_W];
            m_sel     <= win;
            busy      <= 1'b1;
            wdog      <= '0;
            state     <= BUSY;
          end
        end
        BUSY: begin
          wdog <= wdog + 1'b1;
          // A real completion beats the watchdog when both land together.
          if (m_done) begin
            rsp_valid <= ONE_HOT << m_sel;
            rsp_data  <= m_rx_data;
            last      <= m_sel;
            lock_hold <= req_lock[m_sel];
            busy      <= 1'b0;
            state     <= IDLE;
          end else if (wdog == WD_LAST) begin
            rsp_valid <= ONE_HOT << m_sel;
            rsp_err   <= 1'b1;
            rsp_data  <= '0;
            last      <= m_sel;
            lock_hold <= 1'b0;
            busy      <= 1'b0;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_spi_req_arbiter.sv
// Scoreboard bench for spi_req_arbiter: requester and SPI slave models,
// expected responses queued at grant and retired at rsp_valid.
module tb_spi_req_arbiter;

  localparam int N = 4;

  typedef struct {
    int         idx;
    logic [7:0] data;
    logic       err;
  } exp_t;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic [N-1:0] req, req_lock;
  logic [8*N-1:0] req_data;
  logic [N-1:0] gnt, rsp_valid;
  logic [7:0]   rsp_data, m_tx_data, m_rx_data;
  logic         rsp_err, busy, m_start, m_done;
  logic [1:0]   m_sel;

  int checks = 0;
  int errors = 0;

  // Requester model: requester i wants target[i]-granted[i] more bytes.
  int         target[N]  = '{default: 0};
  int         granted[N] = '{default: 0};
  logic [7:0] tx_base[N] = '{8'h10, 8'h20, 8'h30, 8'h40};
  logic [N-1:0] lock_en  = '0;

  // Slave model controls.
  logic       slave_en    = 1'b1;
  logic       slave_fixed = 1'b0;
  logic [7:0] fixed_rx    = 8'h00;
  int         slave_delay = 3;

  exp_t       exp_q[$];
  int         gnt_log[$];
  int         cyc = 0;
  int         start_cyc = 0;
  int         last_lat = 0;
  logic [7:0] last_data = 8'h00;
  logic       last_err = 1'b0;

  spi_req_arbiter #(.N_REQ(N), .TIMEOUT(64)) dut (
    .clk       (clk),
    .rst       (rst),
    .req       (req),
    .req_lock  (req_lock),
    .req_data  (req_data),
    .gnt       (gnt),
    .rsp_valid (rsp_valid),
    .rsp_data  (rsp_data),
    .rsp_err   (rsp_err),
    .busy      (busy),
    .m_start   (m_start),
    .m_tx_data (m_tx_data),
    .m_sel     (m_sel),
    .m_done    (m_done),
    .m_rx_data (m_rx_data)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  always_comb begin
    for (int i = 0; i < N; i++) begin
      req[i]             = target[i] > granted[i];
      req_lock[i]        = lock_en[i] && (target[i] > granted[i]);
      req_data[i*8 +: 8] = tx_base[i] + 8'(granted[i] * 17);
    end
  end

  // SPI slave: answers each m_start after slave_delay negedges.
  initial begin
    m_done    = 1'b0;
    m_rx_data = 8'h00;
    forever begin
      @(negedge clk);
      if (m_start && slave_en) begin
        repeat (slave_delay) @(negedge clk);
        m_done    = 1'b1;
        m_rx_data = slave_fixed ? fixed_rx : (m_tx_data ^ 8'hFF);
        @(negedge clk);
        m_done = 1'b0;
      end
    end
  end

  // Grant/response monitor and scoreboard.
  initial begin
    int         gi, ri;
    logic [7:0] exp_tx;
    exp_t       e;
    forever begin
      @(negedge clk);
      if (gnt != '0) begin
        gi = 0;
        for (int i = 0; i < N; i++) if (gnt[i]) gi = i;
        checks++;
        if (!$onehot(gnt) || m_start !== 1'b1 || busy !== 1'b1) begin
          errors++;
          $display("FAIL grant_pulse: gnt=%b m_start=%b busy=%b, want onehot,1,1", gnt, m_start, busy);
        end
        exp_tx = tx_base[gi] + 8'(granted[gi] * 17);
        checks++;
        if (m_sel !== 2'(gi) || m_tx_data !== exp_tx) begin
          errors++;
          $display("FAIL grant_route: m_sel=%0d m_tx_data=%h, want %0d %h", m_sel, m_tx_data, gi, exp_tx);
        end
        e.idx  = gi;
        e.err  = !slave_en;
        e.data = !slave_en ? 8'h00 : (slave_fixed ? fixed_rx : (exp_tx ^ 8'hFF));
        exp_q.push_back(e);
        granted[gi]++;
        start_cyc = cyc;
        gnt_log.push_back(gi);
      end
      if (rsp_valid != '0) begin
        ri = 0;
        for (int i = 0; i < N; i++) if (rsp_valid[i]) ri = i;
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL rsp_unexpected: rsp_valid=%b, want none", rsp_valid);
        end else begin
          e = exp_q.pop_front();
          if (!$onehot(rsp_valid) || ri != e.idx || rsp_data !== e.data ||
              rsp_err !== e.err || busy !== 1'b0) begin
            errors++;
            $display("FAIL rsp: valid=%b data=%h err=%b busy=%b, want idx %0d data %h err %b busy 0",
                     rsp_valid, rsp_data, rsp_err, busy, e.idx, e.data, e.err);
          end
          last_data = rsp_data;
          last_err  = rsp_err;
          last_lat  = cyc - start_cyc;
        end
      end
    end
  end

  task automatic wait_done(input int budget);
    int n = 0;
    @(negedge clk);
    while ((req != '0 || busy || exp_q.size() != 0) && n < budget) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (n >= budget) begin
      errors++;
      $display("FAIL wait_done: still busy after %0d cycles, want idle", n);
    end
  endtask

  task automatic apply_reset();
    @(negedge clk);
    rst = 1'b1;
    exp_q.delete();
    repeat (2) @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(negedge clk);
    checks++;
    if ({gnt, rsp_valid, rsp_err, busy, m_start, rsp_data, m_tx_data, m_sel} !== '0) begin
      errors++;
      $display("FAIL reset_outputs: gnt=%b rv=%b err=%b busy=%b st=%b rd=%h tx=%h sel=%0d, want all 0",
               gnt, rsp_valid, rsp_err, busy, m_start, rsp_data, m_tx_data, m_sel);
    end
    rst = 1'b0;
  endtask

  task automatic test_single();
    slave_en    = 1'b1;
    slave_fixed = 1'b1;
    fixed_rx    = 8'h3C;
    slave_delay = 5;
    tx_base[2]  = 8'hA5 - 8'(granted[2] * 17);
    target[2]   = granted[2] + 1;
    @(negedge clk);
    checks++;
    if (gnt !== 4'b0100 || m_start !== 1'b1 || m_sel !== 2'd2 || m_tx_data !== 8'hA5) begin
      errors++;
      $display("FAIL single_latency: gnt=%b m_start=%b sel=%0d tx=%h, want 0100 1 2 a5",
               gnt, m_start, m_sel, m_tx_data);
    end
    wait_done(100);
    checks++;
    if (last_data !== 8'h3C || last_err !== 1'b0) begin
      errors++;
      $display("FAIL single_rsp: data=%h err=%b, want 3c 0", last_data, last_err);
    end
    checks++;
    if (m_sel !== 2'd2 || m_tx_data !== 8'hA5) begin
      errors++;
      $display("FAIL single_hold: sel=%0d tx=%h, want 2 a5", m_sel, m_tx_data);
    end
  endtask

  task automatic check_order(input string name, input int exp_order[]);
    checks++;
    if (gnt_log.size() != exp_order.size()) begin
      errors++;
      $display("FAIL %s_count: %0d grants, want %0d", name, gnt_log.size(), exp_order.size());
    end else begin
      for (int i = 0; i < exp_order.size(); i++) begin
        checks++;
        if (gnt_log[i] != exp_order[i]) begin
          errors++;
          $display("FAIL %s_order[%0d]: got %0d, want %0d", name, i, gnt_log[i], exp_order[i]);
        end
      end
    end
  endtask

  task automatic test_fairness();
    apply_reset();
    gnt_log.delete();
    slave_fixed = 1'b0;
    slave_delay = 3;
    target[0] = granted[0] + 2;
    target[1] = granted[1] + 2;
    target[2] = granted[2] + 1;
    target[3] = granted[3] + 1;
    wait_done(400);
    check_order("fair", '{0, 1, 2, 3, 0, 1});
  endtask

  task automatic test_burst_lock();
    apply_reset();
    gnt_log.delete();
    lock_en   = 4'b0001;
    target[0] = granted[0] + 3;
    target[1] = granted[1] + 1;
    wait_done(400);
    lock_en = '0;
    check_order("burst", '{0, 0, 0, 1});
  endtask

  task automatic test_timeout();
    slave_en  = 1'b0;
    target[1] = granted[1] + 1;
    wait_done(300);
    checks++;
    if (last_err !== 1'b1 || last_data !== 8'h00 || last_lat != 64 || busy !== 1'b0) begin
      errors++;
      $display("FAIL timeout: err=%b data=%h lat=%0d busy=%b, want 1 00 64 0",
               last_err, last_data, last_lat, busy);
    end
    slave_en    = 1'b1;
    slave_delay = 4;
    target[1]   = granted[1] + 1;
    wait_done(100);
    checks++;
    if (last_err !== 1'b0 || last_lat != 5) begin
      errors++;
      $display("FAIL after_timeout: err=%b lat=%0d, want 0 5", last_err, last_lat);
    end
  endtask

  task automatic test_collision();
    slave_en    = 1'b1;
    slave_fixed = 1'b1;
    fixed_rx    = 8'h5A;
    slave_delay = 63;
    target[3]   = granted[3] + 1;
    wait_done(300);
    checks++;
    if (last_err !== 1'b0 || last_data !== 8'h5A || last_lat != 64) begin
      errors++;
      $display("FAIL collision: err=%b data=%h lat=%0d, want 0 5a 64", last_err, last_data, last_lat);
    end
    slave_fixed = 1'b0;
    slave_delay = 3;
  endtask

  task automatic test_reset_mid_busy();
    int n = 0;
    slave_en  = 1'b0;
    target[2] = granted[2] + 1;
    while (!m_start && n < 20) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (!m_start) begin
      errors++;
      $display("FAIL mid_start: m_start=%b, want 1", m_start);
    end
    repeat (10) @(negedge clk);
    rst = 1'b1;
    exp_q.delete();
    @(negedge clk);
    checks++;
    if ({gnt, rsp_valid, rsp_err, busy, m_start, rsp_data, m_tx_data, m_sel} !== '0) begin
      errors++;
      $display("FAIL mid_reset_outputs: gnt=%b rv=%b err=%b busy=%b st=%b rd=%h tx=%h sel=%0d, want all 0",
               gnt, rsp_valid, rsp_err, busy, m_start, rsp_data, m_tx_data, m_sel);
    end
    rst = 1'b0;
    repeat (3) @(negedge clk);
    checks++;
    if (rsp_valid !== '0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL mid_reset_silent: rsp_valid=%b busy=%b, want 0 0", rsp_valid, busy);
    end
    slave_en = 1'b1;
    gnt_log.delete();
    target[0] = granted[0] + 1;
    target[3] = granted[3] + 1;
    wait_done(200);
    check_order("post_reset", '{0, 3});
  endtask

  initial begin
    test_reset();
    test_single();
    test_fairness();
    test_burst_lock();
    test_timeout();
    test_collision();
    test_reset_mid_busy();
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain: %0d pending, want 0", exp_q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish, want finish");
    $fatal(1);
  end

endmodule
